muldiv_unit: RTL

//  Iterative RV32M/RV64M multiply/divide execute unit beside the single-cycle ALU.

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_step.sv | 40 ++++
 rtl/muldiv_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the M-extension multiply/divide unit: funct3 codes, FSM states, operand-sign helpers.
package muldiv_pkg;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } muldiv_func3_t;

  localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} muldiv_state_t;

  function automatic logic rs1_is_signed(muldiv_func3_t f);
    return f inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
  endfunction

  function automatic logic rs2_is_signed(muldiv_func3_t f);
    return f inside {F3_MULH, F3_DIV, F3_REM};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational radix-2^BITS iteration over the {hi,lo} working register:
// shift-add for multiply, restoring trial-subtract for divide.
module muldiv_step #(
  parameter int XLEN = 32,
  parameter int BITS = 1
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] opb_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN-1:0] hi, lo;
  logic [XLEN:0]   sum, sh, diff;

  always_comb begin
    hi   = hi_i;
    lo   = lo_i;
    sum  = '0;
    sh   = '0;
    diff = '0;
    for (int i = 0; i < BITS; i++) begin
      if (is_div) begin
        // Remainder stays below the divisor, so XLEN+1 bits hold the shifted trial value.
        sh   = {hi, lo[XLEN-1]};
        diff = sh - {1'b0, opb_i};
        hi   = diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
        lo   = {lo[XLEN-2:0], ~diff[XLEN]};
      end else begin
        sum      = {1'b0, hi} + (lo[0] ? {1'b0, opb_i} : '0);
        {hi, lo} = {sum, lo[XLEN-1:1]};
      end
    end
    hi_o = hi;
    lo_o = lo;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: IDLE -> BUSY (XLEN/BITS_PER_CYCLE steps) -> DONE,
// with divide-by-zero and signed-overflow results produced directly from IDLE.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  muldiv_func3_t   in_func3,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result
);

  if (!((XLEN == 32 || XLEN == 64) &&
        (BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4))) begin : g_bad_param
    $fatal(1, "muldiv_unit: unsupported XLEN=%0d / BITS_PER_CYCLE=%0d", XLEN, BITS_PER_CYCLE);
  end

  localparam int N     = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t   state_q, state_d;
  muldiv_func3_t   func_q, func_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            neg_q, neg_d, in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d, result_q, result_d;

  // Request decode, evaluated every cycle but only used on accept
  logic            a_neg, b_neg, in_is_rem, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  assign a_neg       = rs1_is_signed(in_func3) & in_rs1[XLEN-1];
  assign b_neg       = rs2_is_signed(in_func3) & in_rs2[XLEN-1];
  assign a_mag       = a_neg ? -in_rs1 : in_rs1;
  assign b_mag       = b_neg ? -in_rs2 : in_rs2;
  assign in_is_rem   = in_func3 inside {F3_REM, F3_REMU};
  assign div_zero    = in_func3[2] && (in_rs2 == '0);
  assign div_ovf     = (in_func3 inside {F3_DIV, F3_REM}) && (in_rs1 == MOST_NEG) && (in_rs2 == '1);
  assign special_res = div_zero ? (in_is_rem ? in_rs1 : '1) : (in_is_rem ? '0 : in_rs1);

  logic [XLEN-1:0]   step_hi, step_lo;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   fin_res;

  muldiv_step #(.XLEN(XLEN), .BITS(BITS_PER_CYCLE)) u_step (
    .is_div (func_q[2]),
    .hi_i   (hi_q),
    .lo_i   (lo_q),
    .opb_i  (opb_q),
    .hi_o   (step_hi),
    .lo_o   (step_lo)
  );

  // Sign fix-up on the final iteration's output
  assign prod_s = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};

  always_comb begin
    fin_res = '0;
    case (func_q)
      F3_MUL:                         fin_res = prod_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:   fin_res = prod_s[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:                fin_res = neg_q ? -step_lo : step_lo;
      default:                        fin_res = neg_q ? -step_hi : step_hi;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    func_d      = func_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    opb_d       = opb_q;
    result_d    = result_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: if (in_valid) begin
        func_d     = in_func3;
        cnt_d      = '0;
        hi_d       = '0;
        lo_d       = in_func3[2] ? a_mag : b_mag;
        opb_d      = in_func3[2] ? b_mag : a_mag;
        neg_d      = in_is_rem ? a_neg : (a_neg ^ b_neg);
        in_ready_d = 1'b0;
        if (div_zero || div_ovf) begin
          state_d     = ST_DONE;
          result_d    = special_res;
          out_valid_d = 1'b1;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d     = ST_DONE;
          result_d    = fin_res;
          out_valid_d = 1'b1;
        end
      end
      ST_DONE: if (out_ready) begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      func_q      <= F3_MUL;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      opb_q       <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      func_q      <= func_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      opb_q       <= opb_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = result_q;

endmodule
